// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
//   Registered (or optionally combinational) ripple-carry full adder.
//   {Cout, S} = A + B + Cin, evaluated at WIDTH+1 bits with no truncation.
//   The datapath is a chain of identical 1-bit full-adder cells; bit i feeds
//   its carry into bit i+1, Cin enters at bit 0 and Cout leaves bit WIDTH-1.
//
// Parameters
//   WIDTH    operand/sum width in bits (1..64)
//   REG_OUT  1: S/Cout registered, one cycle of latency, synchronous reset
//            0: S/Cout follow the inputs combinationally; clk/rst unused
//
// Ports
//   clk   in   1      rising-edge clock
//   rst   in   1      synchronous reset, active-high (clears S and Cout)
//   S     out  WIDTH  sum
//   Cout  out  1      carry out of the top bit (unsigned overflow)
//   A     in   WIDTH  operand A
//   B     in   WIDTH  operand B
//   Cin   in   1      carry into bit 0
// -----------------------------------------------------------------------------
module full_adder #(
  parameter int WIDTH   = 1,
  parameter bit REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin
);

  // carry_s[i] is the carry into bit i; carry_s[WIDTH] is the final carry out.
  logic [WIDTH:0]   carry_s;
  logic [WIDTH-1:0] sum_s;

  assign carry_s[0] = Cin;

  // One full-adder cell per bit, rippling the carry upward.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic half_s;  // a ^ b, shared by the sum and the propagate term
    assign half_s         = A[i] ^ B[i];
    assign sum_s[i]       = half_s ^ carry_s[i];
    assign carry_s[i + 1] = (A[i] & B[i]) | (carry_s[i] & half_s);
  end

  if (REG_OUT) begin : g_reg
    logic [WIDTH-1:0] s_r;
    logic             cout_r;

    // Output register: reset wins over capture; otherwise take this cycle's sum.
    always_ff @(posedge clk) begin
      if (rst) begin
        s_r    <= {WIDTH{1'b0}};
        cout_r <= 1'b0;
      end else begin
        s_r    <= sum_s;
        cout_r <= carry_s[WIDTH];
      end
    end

    assign S    = s_r;
    assign Cout = cout_r;
  end else begin : g_comb
    // clk and rst play no part in the combinational variant; fold them into a
    // sink so they are visibly consumed.
    logic unused_clk_rst_s;
    assign unused_clk_rst_s = clk ^ rst;

    assign S    = sum_s;
    assign Cout = carry_s[WIDTH];
  end

endmodule

// File: tb/tb_full_adder.sv
// -----------------------------------------------------------------------------
// tb_full_adder
//   Self-checking bench for full_adder. Four instances run side by side:
//   registered WIDTH=1/4/8 and combinational WIDTH=1. A behavioural model
//   (plain integer addition sampled at each rising edge) predicts every
//   registered output; one compare process checks all instances on every
//   falling edge. Directed steps additionally pin hand-computed literals.
// -----------------------------------------------------------------------------
module tb_full_adder;

  logic clk = 1'b0;
  logic rst;

  // registered WIDTH=1
  logic       a1, b1, cin1, s1, c1;
  // registered WIDTH=4
  logic [3:0] a4, b4, s4;
  logic       cin4, c4;
  // registered WIDTH=8
  logic [7:0] a8, b8, s8;
  logic       cin8, c8;
  // combinational WIDTH=1
  logic       a0, b0, cin0, s0, c0;

  // model state: expected registered outputs after the latest rising edge
  logic [1:0] exp1;   // {Cout,S}
  logic [4:0] exp4;
  logic [8:0] exp8;
  logic       model_valid = 1'b0;

  int checks = 0;
  int errors = 0;

  // Hand-computed (Cin,A,B) -> {S,Cout} for the single-bit cell.
  logic [1:0] t1_exp [8] = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};

  full_adder #(.WIDTH(1), .REG_OUT(1'b1)) u_w1 (
    .clk(clk), .rst(rst), .S(s1), .Cout(c1), .A(a1), .B(b1), .Cin(cin1));
  full_adder #(.WIDTH(4), .REG_OUT(1'b1)) u_w4 (
    .clk(clk), .rst(rst), .S(s4), .Cout(c4), .A(a4), .B(b4), .Cin(cin4));
  full_adder #(.WIDTH(8), .REG_OUT(1'b1)) u_w8 (
    .clk(clk), .rst(rst), .S(s8), .Cout(c8), .A(a8), .B(b8), .Cin(cin8));
  full_adder #(.WIDTH(1), .REG_OUT(1'b0)) u_comb (
    .clk(clk), .rst(rst), .S(s0), .Cout(c0), .A(a0), .B(b0), .Cin(cin0));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Model: what each registered adder must hold after this edge.
  always @(posedge clk) begin
    if (rst) begin
      exp1 = 2'd0;
      exp4 = 5'd0;
      exp8 = 9'd0;
    end else begin
      exp1 = 2'(a1) + 2'(b1) + 2'(cin1);
      exp4 = 5'(a4) + 5'(b4) + 5'(cin4);
      exp8 = 9'(a8) + 9'(b8) + 9'(cin8);
    end
    model_valid = 1'b1;
  end

  // Compare process: every falling edge, all instances against the model.
  always @(negedge clk) begin
    if (model_valid) begin
      check("w1_model", {62'd0, c1, s1}, {62'd0, exp1});
      check("w4_model", {59'd0, c4, s4}, {59'd0, exp4});
      check("w8_model", {55'd0, c8, s8}, {55'd0, exp8});
    end
    check("comb_model", {62'd0, c0, s0}, 64'(2'(a0) + 2'(b0) + 2'(cin0)));
  end

  // Advance to 3 ns after the next rising edge (registered outputs settled).
  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  initial begin
    rst = 1'b1;
    a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    a0 = 1'b0; b0 = 1'b0; cin0 = 1'b0;

    // T2: reset held for two edges with all-ones inputs, then release.
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("t2_rst_w1", {62'd0, s1, c1}, 64'd0);
      check("t2_rst_w8", {55'd0, c8, s8}, 64'd0);
    end
    rst = 1'b0;
    tick();
    check("t2_release", {62'd0, s1, c1}, 64'b11);

    // T1: exhaustive single-bit table, index bits = {Cin,A,B}.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      cin1 = v[2]; a1 = v[1]; b1 = v[0];
      tick();
      check("t1_dut",   {62'd0, s1, c1}, {62'd0, t1_exp[i]});
      check("t1_model", {62'd0, exp1[0], exp1[1]}, {62'd0, t1_exp[i]});
    end

    // T3: inputs alternate each cycle, one-cycle reset in the middle.
    for (int k = 0; k < 6; k++) begin
      logic [1:0] want;
      if (k[0]) begin
        cin1 = 1'b0; a1 = 1'b1; b1 = 1'b0; want = 2'b10;
      end else begin
        cin1 = 1'b1; a1 = 1'b1; b1 = 1'b1; want = 2'b11;
      end
      rst = (k == 3);
      tick();
      check("t3_dut", {62'd0, s1, c1}, (k == 3) ? 64'd0 : {62'd0, want});
    end
    rst = 1'b0;

    // T4: carry ripple through all four bits, then no-carry full sum.
    a4 = 4'hF; b4 = 4'h0; cin4 = 1'b1;
    tick();
    check("t4_ripple",       {59'd0, c4, s4}, 64'h10);
    check("t4_ripple_model", {59'd0, exp4},   64'h10);
    a4 = 4'h7; b4 = 4'h8; cin4 = 1'b0;
    tick();
    check("t4_nocarry",       {59'd0, c4, s4}, 64'h0F);
    check("t4_nocarry_model", {59'd0, exp4},   64'h0F);

    // T4b: 8-bit boundary pins.
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    tick();
    check("w8_max", {55'd0, c8, s8}, 64'h1FF);
    a8 = 8'h80; b8 = 8'h7F; cin8 = 1'b0;
    tick();
    check("w8_nocarry", {55'd0, c8, s8}, 64'h0FF);

    // T5: random vectors on all registered widths; the compare process checks.
    for (int n = 0; n < 1000; n++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
      a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
      tick();
    end

    // T6: combinational instance, 10 ns steps, rst toggling underneath.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      cin0 = v[2]; a0 = v[1]; b0 = v[0];
      rst = v[0];
      #1;
      check("t6_comb", {62'd0, s0, c0}, {62'd0, t1_exp[i]});
      rst = ~rst;
      #1;
      check("t6_comb_rst", {62'd0, s0, c0}, {62'd0, t1_exp[i]});
      #8;
    end
    rst = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
